// File: rtl/bp_be_scoreboard_mc.sv
// bp_be_scoreboard_mc: counting register scoreboard for the dual-issue BE checker.
// Each architectural register holds a small count of in-flight writes, so
// back-to-back writers to one rd and several score/clear events in one cycle stay exact.
// Optional feature: define BP_BE_SCOREBOARD_CLEAR_BYPASS_EN to let the rs/rd lookups
// see same-cycle clears. A consumer can then issue in its producer's writeback cycle.

package bp_be_scoreboard_mc_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    // Architectural register address width supplied by the processor configuration.
    function automatic int reg_addr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 5;
            default:          return 5;
        endcase
    endfunction

endpackage

module bp_be_scoreboard_mc
    import bp_be_scoreboard_mc_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_default_cfg,
    parameter int         num_score_p      = 2,
    parameter int         num_clear_p      = 2,
    parameter int         num_rs_p         = 4,
    parameter int         num_rd_p         = 2,
    parameter int         cnt_width_p      = 2,
    parameter int         zero_hardwired_p = 1,
    parameter int         reg_addr_width_p = reg_addr_width(bp_params_p)
) (
    input  logic                                         clk_i,
    input  logic                                         reset_n_i,
    input  logic [num_score_p-1:0]                       score_v_i,
    input  logic [num_score_p-1:0][reg_addr_width_p-1:0] score_rd_i,
    output logic                                         score_ready_o,
    input  logic [num_clear_p-1:0]                       clear_v_i,
    input  logic [num_clear_p-1:0][reg_addr_width_p-1:0] clear_rd_i,
    input  logic [num_rs_p-1:0][reg_addr_width_p-1:0]    rs_i,
    input  logic [num_rd_p-1:0][reg_addr_width_p-1:0]    rd_i,
    output logic [num_rs_p-1:0]                          rs_match_o,
    output logic [num_rd_p-1:0]                          rd_match_o,
    output logic                                         busy_o,
    output logic                                         underflow_o
);

    localparam int num_regs_lp = 1 << reg_addr_width_p;
    // Wide enough for a full counter plus every port hitting one register.
    localparam int acc_width_lp = cnt_width_p + $clog2(num_score_p + num_clear_p + 1) + 1;

    typedef logic [acc_width_lp-1:0] acc_t;
    typedef logic [cnt_width_p-1:0]  cnt_t;

    localparam acc_t cnt_max_lp = acc_t'((1 << cnt_width_p) - 1);

    cnt_t cnt_q [num_regs_lp];
    cnt_t cnt_d [num_regs_lp];
    acc_t inc   [num_regs_lp];
    acc_t dec   [num_regs_lp];

    logic                   underflow_q;
    logic                   underflow_set;
    logic [num_score_p-1:0] score_live;
    logic [num_clear_p-1:0] clear_live;

    // Drop x0 events when x0 is hardwired, so they neither count nor block acceptance.
    always_comb begin
        for (int i = 0; i < num_score_p; i++)
            score_live[i] = score_v_i[i] && !((zero_hardwired_p != 0) && (score_rd_i[i] == '0));
        for (int i = 0; i < num_clear_p; i++)
            clear_live[i] = clear_v_i[i] && !((zero_hardwired_p != 0) && (clear_rd_i[i] == '0));
    end

    // Scores are all-or-nothing: refuse the whole group if any rd would overflow its counter.
    // Same-cycle clears are deliberately ignored here, which keeps the check conservative.
    always_comb begin
        acc_t same_cnt;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        same_cnt      = '0;
        score_ready_o = 1'b1;
        for (int i = 0; i < num_score_p; i++) begin
            same_cnt = '0;
            for (int j = 0; j < num_score_p; j++)
                if (score_live[j] && (score_rd_i[j] == score_rd_i[i]))
                    same_cnt = same_cnt + acc_t'(1);
            if (score_live[i] && ((acc_t'(cnt_q[score_rd_i[i]]) + same_cnt) > cnt_max_lp))
                score_ready_o = 1'b0;
        end
    end

    // Per-register increment and decrement counts for this cycle.
    always_comb begin
        for (int r = 0; r < num_regs_lp; r++) begin
            inc[r] = '0;
            dec[r] = '0;
            for (int i = 0; i < num_score_p; i++)
                if (score_live[i] && score_ready_o && (score_rd_i[i] == reg_addr_width_p'(r)))
                    inc[r] = inc[r] + acc_t'(1);
            for (int i = 0; i < num_clear_p; i++)
                if (clear_live[i] && (clear_rd_i[i] == reg_addr_width_p'(r)))
                    dec[r] = dec[r] + acc_t'(1);
        end
    end

    // Net update per register. A same-cycle score and clear cancel out. More clears than
    // in-flight writes (including this cycle's scores) saturate at zero and raise underflow.
    always_comb begin
        acc_t sum;
        sum           = '0;
        underflow_set = 1'b0;
        for (int r = 0; r < num_regs_lp; r++) begin
            sum = acc_t'(cnt_q[r]) + inc[r];
            if (sum < dec[r]) begin
                cnt_d[r]      = '0;
                underflow_set = 1'b1;
            end else begin
                cnt_d[r] = cnt_t'(sum - dec[r]);
            end
        end
    end

    // Hazard lookups and drain indicator from registered state (optionally bypassing clears).
    always_comb begin
        for (int k = 0; k < num_rs_p; k++) begin
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
            rs_match_o[k] = acc_t'(cnt_q[rs_i[k]]) > dec[rs_i[k]];
`else
            rs_match_o[k] = cnt_q[rs_i[k]] != '0;
`endif
            if ((zero_hardwired_p != 0) && (rs_i[k] == '0))
                rs_match_o[k] = 1'b0;
        end
        for (int k = 0; k < num_rd_p; k++) begin
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
            rd_match_o[k] = acc_t'(cnt_q[rd_i[k]]) > dec[rd_i[k]];
`else
            rd_match_o[k] = cnt_q[rd_i[k]] != '0;
`endif
            if ((zero_hardwired_p != 0) && (rd_i[k] == '0))
                rd_match_o[k] = 1'b0;
        end
        busy_o = 1'b0;
        for (int r = 0; r < num_regs_lp; r++)
            if (cnt_q[r] != '0)
                busy_o = 1'b1;
    end

    assign underflow_o = underflow_q;

    // Counter array and sticky underflow flag; reset wins over any same-cycle event.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            // NOTE: the counter array is reset explicitly. A stale count would be read as a
            // pending write and stall issue forever, so it cannot be left uninitialised.
            for (int r = 0; r < num_regs_lp; r++)
                cnt_q[r] <= '0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            for (int r = 0; r < num_regs_lp; r++)
                cnt_q[r] <= cnt_d[r];
            if (underflow_set)
                underflow_q <= 1'b1;
        end
    end

endmodule
